// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of a FIFO among
// NUM_REQ requesters. One requester owns the port at a time, for a burst of
// up to MAX_BURST beats. Writes are gated on fifo_full, so the arbiter never
// overflows the FIFO. Lives in the FIFO write-clock domain and drives the
// FIFO wr_en/wdata inputs directly.
//
// Handshake: req[i] acts as "valid" for requester i, and the data on its
// req_data slice is held stable while req[i] is high. "Ready" for requester
// i is gnt[i] & !fifo_full. A beat (one FIFO write) happens in exactly the
// cycles where valid and ready are both high. The requester sees such a
// cycle as accepted and presents its next word in the following cycle.
// Dropping req while granted ends the burst, and that cycle carries no beat.
//
// Ports:
//   clk        - FIFO write clock
//   rst        - asynchronous, active-low reset
//   req        - per-requester write request
//   req_data   - requester i data at [i*WIDTH +: WIDTH]
//   fifo_full  - full flag from the FIFO
//   gnt        - registered grant, one-hot or zero
//   fifo_wr_en - write strobe to the FIFO (a beat)
//   fifo_wdata - data to the FIFO (slice of the granted requester, else 0)
//   active_id  - index of the granted requester, 0 when idle
//   beat_cnt   - beats accepted so far in the current burst
//   busy       - FSM state exposure: high in BURST
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_WIDTH  = $clog2(NUM_REQ),
  parameter int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic                       fifo_full,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_wdata,
  output logic [ID_WIDTH-1:0]        active_id,
  output logic [CNT_WIDTH-1:0]       beat_cnt,
  output logic                       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;

  logic                req_act;
  logic                gnt_act;
  logic                beat;
  logic                last_beat;
  logic [ID_WIDTH-1:0] next_ptr;
  logic                pick_vld;
  logic [ID_WIDTH-1:0] pick_id;

  // Modulo-NUM_REQ add for the round-robin search. The wrap is an explicit
  // compare, so NUM_REQ need not be a power of two.
  function automatic logic [ID_WIDTH-1:0] rr_index(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_WIDTH'(s);
  endfunction

  assign busy      = (state == BURST);
  assign req_act   = req[active_id];
  assign gnt_act   = gnt[active_id];
  assign beat      = req_act & gnt_act & ~fifo_full;
  assign last_beat = beat && (beat_cnt == CNT_WIDTH'(MAX_BURST - 1));

  assign fifo_wr_en = beat;
  // The data path follows gnt rather than beat. wdata is therefore visible
  // during a stall, but it is only written when wr_en is high.
  assign fifo_wdata = (|gnt) ? req_data[active_id*WIDTH +: WIDTH] : '0;

  // Pointer for the next arbitration: the requester just after the one that
  // finished, wrapping at NUM_REQ-1.
  assign next_ptr = (active_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                          : active_id + ID_WIDTH'(1);

  // Search order is rr_ptr, rr_ptr+1, ... (mod NUM_REQ). The first hit wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && req[rr_index(int'(rr_ptr), k)]) begin
        pick_vld = 1'b1;
        pick_id  = rr_index(int'(rr_ptr), k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      active_id <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Always at least one IDLE cycle between bursts: this is the
          // arbitration bubble.
          if (pick_vld && !fifo_full) begin
            state     <= BURST;
            gnt       <= NUM_REQ'(1) << pick_id;
            active_id <= pick_id;
            beat_cnt  <= '0;
          end
        end
        BURST: begin
          // A request drop wins over fifo_full. A full FIFO with req still
          // high just stalls, holding the grant and the count.
          if (!req_act || last_beat) begin
            state     <= IDLE;
            gnt       <= '0;
            active_id <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= next_ptr;
          end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int ID_WIDTH  = 2;
  localparam int CNT_WIDTH = 3;
  localparam int N_VEC     = 27;
  localparam int N_RND     = 3000;

  // ---------------- clock / reset ----------------
  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     fifo_full;
  logic [NUM_REQ-1:0]       gnt;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wdata;
  logic [ID_WIDTH-1:0]      active_id;
  logic [CNT_WIDTH-1:0]     beat_cnt;
  logic                     busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH    (WIDTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .gnt       (gnt),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata),
    .active_id (active_id),
    .beat_cnt  (beat_cnt),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Holds reset for two edges, then releases it just after a rising edge.
  task automatic do_reset(input logic [NUM_REQ-1:0] r);
    rst       = 1'b0;
    req       = r;
    fifo_full = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic                 full;
    logic [NUM_REQ-1:0]   gnt;
    logic                 wr;
    logic [WIDTH-1:0]     wdata;
    logic                 busy;
    logic [ID_WIDTH-1:0]  id;
    logic [CNT_WIDTH-1:0] cnt;
  } vec_t;

  vec_t tbl[N_VEC];

  function automatic vec_t v(input logic r, input logic [3:0] q, input logic f,
                             input logic [3:0] g, input logic w, input logic [7:0] d,
                             input logic b, input logic [1:0] i, input logic [2:0] c);
    vec_t t;
    t.rst = r; t.req = q; t.full = f; t.gnt = g; t.wr = w;
    t.wdata = d; t.busy = b; t.id = i; t.cnt = c;
    return t;
  endfunction

  // ---------------- reference model ----------------
  // First requester at or after p (mod NUM_REQ) that is asking, or -1.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]         d;
    logic [NUM_REQ-1:0] prev_g;
    int                 ids[$];
    int                 lens[$];
    int                 cur_len;
    int                 idle_run;
    int                 rr_exp[3];
    logic               found;
    int                 owner;
    int                 beats;
    int                 ptr;
    int                 p;
    logic [7:0]         data_r[NUM_REQ];
    logic [NUM_REQ-1:0] exp_g;
    logic               exp_wr;
    logic [7:0]         exp_wd;
    logic [7:0]         exp_sb;
    logic [7:0]         exp_burst_d[7];
    logic [3:0]         exp_burst_g[7];
    logic               exp_burst_w[7];

    rst       = 1'b0;
    req       = '1;
    fifo_full = 1'b0;
    req_data  = 32'hD3C2_B1A0;

    // ---------- table-driven vectors ----------
    //          rst req      full  gnt      wr  wdata  busy id cnt
    tbl[0]  = v(0, 4'b1111, 0,   4'b0000, 0, 8'h00, 0,   0, 0);
    tbl[1]  = v(0, 4'b1111, 0,   4'b0000, 0, 8'h00, 0,   0, 0);
    tbl[2]  = v(1, 4'b1111, 0,   4'b0000, 0, 8'h00, 0,   0, 0);
    tbl[3]  = v(1, 4'b1111, 0,   4'b0001, 1, 8'hA0, 1,   0, 0);
    tbl[4]  = v(1, 4'b1111, 0,   4'b0001, 1, 8'hA0, 1,   0, 1);
    tbl[5]  = v(1, 4'b1111, 0,   4'b0001, 1, 8'hA0, 1,   0, 2);
    tbl[6]  = v(1, 4'b1111, 0,   4'b0001, 1, 8'hA0, 1,   0, 3);
    tbl[7]  = v(1, 4'b1111, 0,   4'b0000, 0, 8'h00, 0,   0, 0);
    tbl[8]  = v(1, 4'b1111, 0,   4'b0010, 1, 8'hB1, 1,   1, 0);
    tbl[9]  = v(1, 4'b1111, 0,   4'b0010, 1, 8'hB1, 1,   1, 1);
    tbl[10] = v(1, 4'b1001, 0,   4'b0010, 0, 8'hB1, 1,   1, 2);
    tbl[11] = v(1, 4'b1001, 0,   4'b0000, 0, 8'h00, 0,   0, 0);
    tbl[12] = v(1, 4'b1001, 0,   4'b1000, 1, 8'hD3, 1,   3, 0);
    tbl[13] = v(1, 4'b1001, 0,   4'b1000, 1, 8'hD3, 1,   3, 1);
    tbl[14] = v(1, 4'b1001, 1,   4'b1000, 0, 8'hD3, 1,   3, 2);
    tbl[15] = v(1, 4'b1001, 1,   4'b1000, 0, 8'hD3, 1,   3, 2);
    tbl[16] = v(1, 4'b1001, 1,   4'b1000, 0, 8'hD3, 1,   3, 2);
    tbl[17] = v(1, 4'b1001, 0,   4'b1000, 1, 8'hD3, 1,   3, 2);
    tbl[18] = v(1, 4'b1001, 0,   4'b1000, 1, 8'hD3, 1,   3, 3);
    tbl[19] = v(1, 4'b1001, 0,   4'b0000, 0, 8'h00, 0,   0, 0);
    tbl[20] = v(1, 4'b1001, 0,   4'b0001, 1, 8'hA0, 1,   0, 0);
    tbl[21] = v(1, 4'b1000, 1,   4'b0001, 0, 8'hA0, 1,   0, 1);
    tbl[22] = v(1, 4'b1000, 1,   4'b0000, 0, 8'h00, 0,   0, 0);
    tbl[23] = v(1, 4'b1000, 1,   4'b0000, 0, 8'h00, 0,   0, 0);
    tbl[24] = v(1, 4'b1000, 0,   4'b0000, 0, 8'h00, 0,   0, 0);
    tbl[25] = v(1, 4'b1000, 0,   4'b1000, 1, 8'hD3, 1,   3, 0);
    tbl[26] = v(0, 4'b1000, 0,   4'b0000, 0, 8'h00, 0,   0, 0);

    for (int k = 0; k < N_VEC; k++) begin
      @(posedge clk); #1;
      rst       = tbl[k].rst;
      req       = tbl[k].req;
      fifo_full = tbl[k].full;
      @(negedge clk);
      check($sformatf("tbl%0d_gnt", k),   32'(gnt),        32'(tbl[k].gnt));
      check($sformatf("tbl%0d_wr", k),    32'(fifo_wr_en), 32'(tbl[k].wr));
      check($sformatf("tbl%0d_wdata", k), 32'(fifo_wdata), 32'(tbl[k].wdata));
      check($sformatf("tbl%0d_busy", k),  32'(busy),       32'(tbl[k].busy));
      check($sformatf("tbl%0d_id", k),    32'(active_id),  32'(tbl[k].id));
      check($sformatf("tbl%0d_cnt", k),   32'(beat_cnt),   32'(tbl[k].cnt));
    end

    // ---------- burst limit with incrementing data on requester 2 ----------
    exp_burst_g = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    exp_burst_w = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_burst_d = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14};
    do_reset(4'b0000);
    @(posedge clk); #1;
    req = 4'b0100;
    d   = 8'h10;
    req_data = {8'h00, d, 16'h0000};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("burst%0d_gnt", c),   32'(gnt),        32'(exp_burst_g[c]));
      check($sformatf("burst%0d_wr", c),    32'(fifo_wr_en), 32'(exp_burst_w[c]));
      check($sformatf("burst%0d_wdata", c), 32'(fifo_wdata), 32'(exp_burst_d[c]));
      if (gnt[2] && !fifo_full) d = d + 8'h01;
      @(posedge clk); #1;
      req_data[23:16] = d;
    end

    // ---------- round-robin order with req=1011 held ----------
    rr_exp   = '{0, 1, 3};
    req_data = 32'hD3C2_B1A0;
    do_reset(4'b1011);
    prev_g   = '0;
    cur_len  = 0;
    idle_run = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      check($sformatf("rr%0d_no_gnt2", c), 32'(gnt[2]), 32'd0);
      if (gnt != 0 && prev_g == 0) begin
        ids.push_back(int'(active_id));
        if (ids.size() > 1) check($sformatf("rr%0d_gap", c), 32'(idle_run), 32'd1);
        cur_len = 0;
      end
      if (gnt == 0) idle_run++;
      else          idle_run = 0;
      if (fifo_wr_en) cur_len++;
      if (gnt == 0 && prev_g != 0) lens.push_back(cur_len);
      prev_g = gnt;
    end
    check("rr_num_bursts", 32'(ids.size() >= 6 && lens.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k < ids.size())  check($sformatf("rr_order%0d", k), 32'(ids[k]), 32'(rr_exp[k % 3]));
      if (k < lens.size()) check($sformatf("rr_len%0d", k), 32'(lens[k]), 32'(MAX_BURST));
    end

    // ---------- async reset mid-burst ----------
    // Requester 0 finishes a burst first, so the pointer has moved on to 1
    // before reset; arbitration must restart from 0 afterwards.
    do_reset(4'b0011);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy && active_id == 2'd1 && beat_cnt == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("arst_reached_beat2", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_gnt",  32'(gnt),        32'd0);
    check("arst_wr",   32'(fifo_wr_en), 32'd0);
    check("arst_busy", 32'(busy),       32'd0);
    check("arst_cnt",  32'(beat_cnt),   32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    check("arst_rel_idle", 32'(gnt), 32'd0);
    @(negedge clk);
    check("arst_rel_gnt", 32'(gnt),       32'b0001);
    check("arst_rel_id",  32'(active_id), 32'd0);

    // ---------- randomized stimulus vs reference model ----------
    for (int i = 0; i < NUM_REQ; i++) data_r[i] = 8'($urandom_range(0, 255));
    do_reset(4'b0000);
    owner = -1;
    beats = 0;
    ptr   = 0;
    for (int cyc = 0; cyc < N_RND; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
        req_data[i*WIDTH +: WIDTH] = data_r[i];
      end
      fifo_full = ($urandom_range(0, 4) == 0);
      @(negedge clk);

      exp_g  = (owner < 0) ? 4'b0000 : 4'(4'b0001 << owner);
      exp_wr = (owner >= 0) && req[owner] && !fifo_full;
      exp_wd = (owner < 0) ? 8'h00 : data_r[owner];
      check($sformatf("rnd%0d_gnt", cyc),  32'(gnt),        32'(exp_g));
      check($sformatf("rnd%0d_wr", cyc),   32'(fifo_wr_en), 32'(exp_wr));
      check($sformatf("rnd%0d_wd", cyc),   32'(fifo_wdata), 32'(exp_wd));
      check($sformatf("rnd%0d_busy", cyc), 32'(busy),       32'(owner >= 0));
      check($sformatf("rnd%0d_id", cyc),   32'(active_id),  32'((owner < 0) ? 0 : owner));
      check($sformatf("rnd%0d_cnt", cyc),  32'(beat_cnt),   32'(beats));
      check($sformatf("rnd%0d_onehot", cyc), 32'($onehot0(gnt)), 32'd1);
      check($sformatf("rnd%0d_wr_full", cyc), 32'(fifo_wr_en & fifo_full), 32'd0);

      if (exp_wr) exp_q.push_back(data_r[owner]);
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rnd%0d_unexpected_write", cyc), 32'd1, 32'd0);
        end else begin
          exp_sb = exp_q.pop_front();
          check($sformatf("rnd%0d_sb_data", cyc), 32'(fifo_wdata), 32'(exp_sb));
        end
      end

      // Advance the model by one clock edge.
      if (owner < 0) begin
        if (!fifo_full) begin
          p = rr_pick(req, ptr);
          if (p >= 0) begin
            owner = p;
            beats = 0;
          end
        end
      end else if (!req[owner]) begin
        ptr   = (owner + 1) % NUM_REQ;
        owner = -1;
        beats = 0;
      end else if (exp_wr) begin
        data_r[owner] = data_r[owner] + 8'h01;
        beats++;
        if (beats == MAX_BURST) begin
          ptr   = (owner + 1) % NUM_REQ;
          owner = -1;
          beats = 0;
        end
      end

      @(posedge clk); #1;
    end
    check("rnd_sb_drained", 32'(exp_q.size()), 32'd0);

    // ---------- final report ----------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
